// File: rtl/pattern_play_pkg.sv
// Shared types and constants for the pattern-play game controller.
// Symbols are 2 bits wide and 2'b11 is never a valid symbol.
package pattern_play_pkg;

  localparam int SYM_W   = 2;
  localparam int MAX_SYM = 9;
  localparam int SEQ_W   = SYM_W * MAX_SYM;
  localparam int LVL_W   = 4;

  localparam logic [SYM_W-1:0] SYM_0   = 2'd0;
  localparam logic [SYM_W-1:0] SYM_1   = 2'd1;
  localparam logic [SYM_W-1:0] SYM_2   = 2'd2;
  localparam logic [SYM_W-1:0] SYM_BAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW_ON,
    ST_SHOW_GAP,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic logic [SYM_W-1:0] sym_at(
    input logic [SEQ_W-1:0] s,
    input logic [LVL_W-1:0] i
  );
    logic [SEQ_W-1:0] sh;
    sh = s >> (SYM_W * int'(i));
    return sh[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/ppc_timer.sv
// Loadable down-counter; expire_o marks the last cycle of a loaded interval.
// Loading N gives exactly N cycles before the owner acts on expire_o.
module ppc_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/pattern_play_ctrl.sv
// Memory-game controller: shows a growing symbol sequence, then checks presses.
// Define PPC_TIMEOUT_EN to lose after TIMEOUT_CYC idle cycles in WAIT_IN.
module pattern_play_ctrl
  import pattern_play_pkg::*;
#(
  parameter int unsigned NUM_SYM     = 9,
  parameter int unsigned SHOW_CYC    = 25000000,
  parameter int unsigned GAP_CYC     = 12500000,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  output logic             gen_start,
  input  logic             gen_done,
  input  logic [SEQ_W-1:0] seq,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_sym,
  output logic             led_on,
  output logic [SYM_W-1:0] led_sym,
  output logic             busy,
  output logic             win,
  output logic             lose,
  output logic [LVL_W-1:0] level
);

  // One timer serves every interval, so it is sized for the longest.
  localparam int unsigned MAX_SG  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_SG > TIMEOUT_CYC) ? MAX_SG : TIMEOUT_CYC;
  localparam int TMR_W = $clog2(MAX_CYC + 1);

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] cur_sym;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;
  logic             sym_ok;

  ppc_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_exp)
  );

  assign cur_sym = sym_at(seq_q, idx_q);
  assign sym_ok  = (btn_sym != SYM_BAD) && (btn_sym == cur_sym);

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    level_d  = level_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_GEN;
      end
      ST_GEN: begin
        if (gen_done) begin
          seq_d    = seq;
          level_d  = LVL_W'(1);
          idx_d    = '0;
          state_d  = ST_SHOW_ON;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SHOW_CYC);
        end
      end
      ST_SHOW_ON: begin
        if (tmr_exp) begin
          state_d  = ST_SHOW_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYC);
        end
      end
      ST_SHOW_GAP: begin
        if (tmr_exp) begin
          if (idx_q + LVL_W'(1) < level_q) begin
            idx_d    = idx_q + LVL_W'(1);
            state_d  = ST_SHOW_ON;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(SHOW_CYC);
          end else begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
`ifdef PPC_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT_CYC);
`endif
          end
        end
      end
      ST_WAIT_IN: begin
        if (btn_valid) begin
`ifdef PPC_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYC);
`endif
          if (!sym_ok) begin
            state_d = ST_LOSE;
          end else if (idx_q != level_q - LVL_W'(1)) begin
            idx_d = idx_q + LVL_W'(1);
          end else if (level_q == LVL_W'(NUM_SYM)) begin
            state_d = ST_WIN;
          end else begin
            level_d  = level_q + LVL_W'(1);
            idx_d    = '0;
            state_d  = ST_SHOW_ON;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(SHOW_CYC);
          end
        end
`ifdef PPC_TIMEOUT_EN
        else if (tmr_exp) begin
          state_d = ST_LOSE;
        end
`endif
      end
      ST_WIN, ST_LOSE: begin
        if (go) state_d = ST_GEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      level_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      level_q <= level_d;
      idx_q   <= idx_d;
    end
  end

  assign gen_start = (state_q == ST_GEN);
  assign led_on    = (state_q == ST_SHOW_ON);
  assign led_sym   = led_on ? cur_sym : SYM_0;
  assign busy      = (state_q == ST_GEN) || (state_q == ST_SHOW_ON) ||
                     (state_q == ST_SHOW_GAP) || (state_q == ST_WAIT_IN);
  assign win       = (state_q == ST_WIN);
  assign lose      = (state_q == ST_LOSE);
  assign level     = level_q;

endmodule

// File: tb/tb_pattern_play_ctrl.sv
// Directed bench for pattern_play_ctrl with short show/gap/timeout intervals.
// Sequence 18'h24924 yields symbols 0,1,2 repeating.
module tb_pattern_play_ctrl;
  import pattern_play_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             go = 1'b0;
  logic             gen_start;
  logic             gen_done = 1'b0;
  logic [SEQ_W-1:0] seq = 18'h24924;
  logic             btn_valid = 1'b0;
  logic [SYM_W-1:0] btn_sym = 2'd0;
  logic             led_on;
  logic [SYM_W-1:0] led_sym;
  logic             busy, win, lose;
  logic [LVL_W-1:0] level;

  int errs = 0;
  int checks = 0;

  pattern_play_ctrl #(
    .NUM_SYM(9), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .gen_start(gen_start),
    .gen_done(gen_done), .seq(seq), .btn_valid(btn_valid),
    .btn_sym(btn_sym), .led_on(led_on), .led_sym(led_sym),
    .busy(busy), .win(win), .lose(lose), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] s);
    btn_sym = s;
    btn_valid = 1'b1;
    tick();
    btn_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    reset_n = 1'b0; go = 1'b1; gen_done = 1'b1; btn_valid = 1'b1;
    tick(); tick();
    outs = {gen_start, led_on, led_sym, busy, win, lose, level};
    checks++;
    if (outs !== 10'd0) begin
      errs++; $display("FAIL reset_outs: got %b want 0", outs);
    end
    reset_n = 1'b1; go = 1'b0; gen_done = 1'b0; btn_valid = 1'b0;
    tick();
    checks++;
    if ({busy, gen_start} !== 2'b00) begin
      errs++; $display("FAIL reset_idle: got %b want 00", {busy, gen_start});
    end
  endtask

  task automatic test_show();
    int on_cnt;
    logic bad_sym;
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if ({gen_start, busy} !== 2'b11) begin
      errs++; $display("FAIL gen_enter: got %b want 11", {gen_start, busy});
    end
    tick(); tick();
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    checks++;
    if ({gen_start, led_on, led_sym, level} !== {1'b0, 1'b1, 2'd0, 4'd1}) begin
      errs++; $display("FAIL show_first: got %b want 01000001",
                       {gen_start, led_on, led_sym, level});
    end
    on_cnt = 1; bad_sym = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (led_on) begin
        on_cnt++;
        if (led_sym !== 2'd0) bad_sym = 1'b1;
      end
    end
    checks++;
    if (on_cnt != 4 || bad_sym) begin
      errs++; $display("FAIL show_len: got %0d cycles bad=%0b want 4 bad=0",
                       on_cnt, bad_sym);
    end
    tick();
    checks++;
    if ({busy, led_on, level} !== {1'b1, 1'b0, 4'd1}) begin
      errs++; $display("FAIL wait_r1: got %b want 1_0_0001", {busy, led_on, level});
    end
    press(2'd0);
    checks++;
    if ({level, led_on, led_sym} !== {4'd2, 1'b1, 2'd0}) begin
      errs++; $display("FAIL round2_sym0: got %b want 0010_1_00",
                       {level, led_on, led_sym});
    end
    repeat (6) tick();
    checks++;
    if ({led_on, led_sym} !== {1'b1, 2'd1}) begin
      errs++; $display("FAIL round2_sym1: got %b want 1_01", {led_on, led_sym});
    end
    repeat (6) tick();
    checks++;
    if ({busy, led_on, level} !== {1'b1, 1'b0, 4'd2}) begin
      errs++; $display("FAIL wait_r2: got %b want 1_0_0010", {busy, led_on, level});
    end
  endtask

  task automatic test_lose();
    press(2'd0);
    checks++;
    if ({busy, led_on, lose, level} !== {1'b1, 1'b0, 1'b0, 4'd2}) begin
      errs++; $display("FAIL partial_press: got %b want 1_0_0_0010",
                       {busy, led_on, lose, level});
    end
    press(2'd1);
    checks++;
    if ({led_on, level} !== {1'b1, 4'd3}) begin
      errs++; $display("FAIL round3_start: got %b want 1_0011", {led_on, level});
    end
    repeat (18) tick();
    press(2'd0);
    press(2'd1);
    checks++;
    if ({busy, lose} !== 2'b10) begin
      errs++; $display("FAIL pre_lose: got %b want 10", {busy, lose});
    end
    press(2'd0);
    checks++;
    if ({lose, win, busy, level} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
      errs++; $display("FAIL lose_r3: got %b want 1_0_0_0011",
                       {lose, win, busy, level});
    end
  endtask

  task automatic test_ignore_in_show();
    go = 1'b1; tick(); go = 1'b0;
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    go = 1'b1; btn_valid = 1'b1; btn_sym = 2'd0;
    tick();
    go = 1'b0; btn_valid = 1'b0;
    checks++;
    if ({led_on, led_sym, level, gen_start, busy} !==
        {1'b1, 2'd0, 4'd1, 1'b0, 1'b1}) begin
      errs++; $display("FAIL ignore_show: got %b want 1_00_0001_0_1",
                       {led_on, led_sym, level, gen_start, busy});
    end
    tick(); tick();
    checks++;
    if (led_on !== 1'b1) begin
      errs++; $display("FAIL ignore_len4: got %b want 1", led_on);
    end
    tick();
    checks++;
    if (led_on !== 1'b0) begin
      errs++; $display("FAIL ignore_gap: got %b want 0", led_on);
    end
    tick(); tick();
    checks++;
    if ({busy, led_on, level} !== {1'b1, 1'b0, 4'd1}) begin
      errs++; $display("FAIL ignore_wait: got %b want 1_0_0001",
                       {busy, led_on, level});
    end
  endtask

  task automatic test_win();
    for (int l = 1; l <= 9; l++) begin
      for (int i = 0; i < l; i++) press(2'(i % 3));
      if (l < 9) begin
        checks++;
        if ({level, led_on, led_sym} !== {4'(l + 1), 1'b1, 2'd0}) begin
          errs++; $display("FAIL round_adv%0d: got %b want %b", l,
                           {level, led_on, led_sym}, {4'(l + 1), 1'b1, 2'd0});
        end
        repeat (6 * (l + 1)) tick();
      end
    end
    checks++;
    if ({win, lose, busy, level} !== {1'b1, 1'b0, 1'b0, 4'd9}) begin
      errs++; $display("FAIL win: got %b want 1_0_0_1001", {win, lose, busy, level});
    end
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if ({gen_start, win} !== 2'b10) begin
      errs++; $display("FAIL restart: got %b want 10", {gen_start, win});
    end
  endtask

  task automatic test_timeout();
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    repeat (6) tick();
`ifdef PPC_TIMEOUT_EN
    repeat (9) tick();
    checks++;
    if ({busy, lose} !== 2'b10) begin
      errs++; $display("FAIL to_cycle10: got %b want 10", {busy, lose});
    end
    press(2'd0);
    checks++;
    if ({level, led_on, lose} !== {4'd2, 1'b1, 1'b0}) begin
      errs++; $display("FAIL to_press_at10: got %b want 0010_1_0",
                       {level, led_on, lose});
    end
    repeat (12) tick();
    repeat (5) tick();
    press(2'd0);
    repeat (9) tick();
    checks++;
    if ({busy, lose} !== 2'b10) begin
      errs++; $display("FAIL to_reload: got %b want 10", {busy, lose});
    end
    tick();
    checks++;
    if ({lose, busy, level} !== {1'b1, 1'b0, 4'd2}) begin
      errs++; $display("FAIL to_expire: got %b want 1_0_0010", {lose, busy, level});
    end
`else
    repeat (1000) tick();
    checks++;
    if ({busy, lose, led_on} !== 3'b100) begin
      errs++; $display("FAIL no_timeout: got %b want 100", {busy, lose, led_on});
    end
    press(2'd0);
    checks++;
    if ({level, led_on} !== {4'd2, 1'b1}) begin
      errs++; $display("FAIL late_press: got %b want 0010_1", {level, led_on});
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [9:0] outs;
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    go = 1'b1; tick(); go = 1'b0;
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    tick();
    checks++;
    if (led_on !== 1'b1) begin
      errs++; $display("FAIL mid_show: got %b want 1", led_on);
    end
    reset_n = 1'b0; go = 1'b1; gen_done = 1'b1; btn_valid = 1'b1; btn_sym = 2'd0;
    tick();
    outs = {gen_start, led_on, led_sym, busy, win, lose, level};
    checks++;
    if (outs !== 10'd0) begin
      errs++; $display("FAIL mid_reset: got %b want 0", outs);
    end
    reset_n = 1'b1; go = 1'b0; gen_done = 1'b0; btn_valid = 1'b0;
    tick();
    checks++;
    if ({busy, level} !== 5'd0) begin
      errs++; $display("FAIL post_reset: got %b want 0", {busy, level});
    end
  endtask

  initial begin
    test_reset();
    test_show();
    test_lose();
    test_ignore_in_show();
    test_win();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
